// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the LC-3b byte-banked memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_WORD = 1'b1;

    localparam int ROW_W = 8;
    localparam int CNT_W = 4;

    // Banks taking part in an access, returned as {hi, lo}.
    function automatic logic [1:0] bank_sel(input logic size, input logic a0);
        return {(size == SZ_WORD) || a0, (size == SZ_WORD) || !a0};
    endfunction

endpackage

// File: rtl/mem_arb.sv
// Two-way alternating-priority arbiter between fetch and data ports.
module mem_arb
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       if_req,
    input  logic       d_req,
    input  logic       en,
    output logic [1:0] grant     // bit 1 = data port, bit 0 = fetch port
);

    port_t last;

    // One-hot grant; on a tie the port not served last wins.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        grant = 2'b00;
        if (en) begin
            if (if_req && d_req)
                grant = (last == PORT_IF) ? 2'b10 : 2'b01;
            else
                grant = {d_req, if_req};
        end
    end

    // Remember which port was granted most recently.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset)
            last <= PORT_IF;
        else if (grant[1])
            last <= PORT_D;
        else if (grant[0])
            last <= PORT_IF;
    end

endmodule

// File: rtl/mem_ctrl.sv
// Sequences fetch and data accesses onto the low/high byte banks with a
// programmable number of access cycles and a one-cycle ready pulse.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int LATENCY = 2     // ACCESS cycles per transaction, 1..15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [15:0]      if_addr,
    output logic [15:0]      if_rdata,
    output logic             if_ready,
    input  logic             d_req,
    input  logic             d_we,
    input  logic             d_size,
    input  logic [15:0]      d_addr,
    input  logic [15:0]      d_wdata,
    output logic [15:0]      d_rdata,
    output logic             d_ready,
    output logic [ROW_W-1:0] lo_addr,
    output logic [ROW_W-1:0] hi_addr,
    output logic [7:0]       lo_wdata,
    output logic [7:0]       hi_wdata,
    output logic             lo_write_n,
    output logic             hi_write_n,
    input  logic [7:0]       lo_rdata,
    input  logic [7:0]       hi_rdata
);

    state_t           state;
    port_t            port;
    logic             we;
    logic             size;
    logic             a0;
    logic [CNT_W-1:0] count;
    logic [1:0]       grant;
    logic [1:0]       d_sel;
    logic [1:0]       cur_sel;
    logic [15:0]      load_data;
    logic             unused_addr_bits;

    // Upper address bits alias and fetches are always word-aligned.
    assign unused_addr_bits = ^{if_addr[15:9], if_addr[0], d_addr[15:9]};

    assign d_sel     = bank_sel(d_size, d_addr[0]);
    assign cur_sel   = bank_sel(size, a0);
    assign load_data = (size == SZ_WORD) ? {hi_rdata, lo_rdata}
                                         : {8'h00, a0 ? hi_rdata : lo_rdata};

    mem_arb u_arb (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .d_req  (d_req),
        .en     (state == IDLE),
        .grant  (grant)
    );

    // Transaction FSM with all bank and port outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            port       <= PORT_IF;
            we         <= 1'b0;
            size       <= SZ_BYTE;
            a0         <= 1'b0;
            count      <= '0;
            lo_addr    <= '0;
            hi_addr    <= '0;
            lo_wdata   <= '0;
            hi_wdata   <= '0;
            lo_write_n <= 1'b1;
            hi_write_n <= 1'b1;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        count <= CNT_W'(LATENCY - 1);
                        state <= ACCESS;
                        if (grant[1]) begin
                            port     <= PORT_D;
                            we       <= d_we;
                            size     <= d_size;
                            a0       <= d_addr[0];
                            lo_addr  <= d_addr[8:1];
                            hi_addr  <= d_addr[8:1];
                            lo_wdata <= d_wdata[7:0];
                            hi_wdata <= (d_size == SZ_WORD) ? d_wdata[15:8] : d_wdata[7:0];
                            // With a single access cycle the strobe window opens right away.
                            if (LATENCY == 1 && d_we) begin
                                lo_write_n <= !d_sel[0];
                                hi_write_n <= !d_sel[1];
                            end
                        end else begin
                            port    <= PORT_IF;
                            we      <= 1'b0;
                            size    <= SZ_WORD;
                            a0      <= 1'b0;
                            lo_addr <= if_addr[8:1];
                            hi_addr <= if_addr[8:1];
                        end
                    end
                end
                ACCESS: begin
                    if (count == '0) begin
                        state      <= DONE;
                        lo_write_n <= 1'b1;
                        hi_write_n <= 1'b1;
                        if (!we) begin
                            if (port == PORT_IF)
                                if_rdata <= load_data;
                            else
                                d_rdata <= load_data;
                        end
                    end else begin
                        count <= count - 1'b1;
                        // Open the strobe for the final access cycle only.
                        if (count == CNT_W'(1) && we) begin
                            lo_write_n <= !cur_sel[0];
                            hi_write_n <= !cur_sel[1];
                        end
                    end
                end
                DONE: begin
                    if (port == PORT_IF)
                        if_ready <= 1'b1;
                    else
                        d_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
